pipe_gen: RTL and testbench
===========================

PIPE_GEN -- requirements
Module: pipe_gen

Interface
REQ-001 The module SHALL have parameter GAP_H, default 3, meaning the gap height in rows; legal range 1..4.
REQ-002 The module SHALL have parameter SPACING, default 4, meaning the number of columns from one pipe to the next; legal range 2..8.
REQ-003 The module SHALL have parameter LFSR_SEED, default 8'hA5, meaning the LFSR reset value; must be non-zero.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port enable, input, 1 bit: scroll tick, one-cycle pulse.
REQ-007 The module SHALL have port halt, input, 1 bit: game over; freezes the field.
REQ-008 The module SHALL have port clear, input, 1 bit: synchronous restart request.
REQ-009 The module SHALL have port green_array, output, [7:0][7:0]: pipe field indexed [row][col]; column 6 is the scoring column consumed by the downstream score stage.
REQ-010 The module SHALL have port spawned, output, 1 bit: one-cycle pulse when a pipe enters column 0.
REQ-011 The module SHALL have port gap_top, output, 3 bits: lowest gap row of the most recent pipe.

Function
REQ-012 The block SHALL implement FSM states IDLE, RUN and FROZEN.
REQ-013 Transition IDLE->RUN SHALL occur on enable & !halt & !clear, and that same tick SHALL be processed as a RUN tick.
REQ-014 Transition RUN->FROZEN SHALL occur on halt & !clear, with no shift that cycle even if enable=1.
REQ-015 Transition from any state to IDLE SHALL occur on clear, which clears green_array, the spacing counter, spawned and gap_top and restores the LFSR to LFSR_SEED.
REQ-016 Priority per cycle SHALL be clear > halt > enable.
REQ-017 In FROZEN, green_array SHALL hold; enable SHALL be ignored and only clear exits the state.
REQ-018 A RUN tick SHALL set column c+1 to the old column c for c = 0..6, discard old column 7, and load column 0 with new content.
REQ-019 A spacing counter sp SHALL run 0..SPACING-1 and advance on every RUN tick, wrapping to 0.
REQ-020 When sp==0 on a tick, column 0 SHALL be a pipe; otherwise column 0 SHALL be all zero.
REQ-021 A pipe column SHALL set every row to 1 except rows gap_top..gap_top+GAP_H-1, which SHALL be 0.
REQ-022 With raw = lfsr[2:0], gap_top SHALL equal raw if raw <= 8-GAP_H, else raw-(9-GAP_H), so the gap never exceeds row 7.
REQ-023 The LFSR SHALL be 8-bit Fibonacci with next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
REQ-024 The LFSR SHALL advance only on a spawn, after its value is used.
REQ-025 spawned SHALL be 1 for exactly the cycle after a spawning tick.
REQ-026 gap_top SHALL update with that same spawned cycle and hold otherwise.
REQ-027 Latency SHALL be one cycle: green_array reflects a tick on the clock edge following the enable cycle.
REQ-028 A pipe SHALL reach column 6 on the 7th RUN tick after it spawns (its spawn tick counted as the 1st).
REQ-029 A pipe SHALL leave the field on the 9th RUN tick.
REQ-030 enable held high SHALL produce one tick per clock, with no internal edge detection.

Reset
REQ-031 On reset=0, asynchronously: green_array=0, sp=0, lfsr=LFSR_SEED, spawned=0, gap_top=0, state=IDLE.
REQ-032 Reset asserted mid-scroll SHALL discard all pipes immediately, without waiting for a clock edge.
REQ-033 On reset release, the block SHALL remain in IDLE until the first qualifying enable.

Verification
REQ-034 The bench SHALL check: reset, then one enable with defaults -> column 0 rows 0..4 = 1, rows 5..7 = 0, spawned pulse, gap_top=5, lfsr=8'h4A.
REQ-035 The bench SHALL check: 4 further single-cycle enables -> columns 1..3 of the new content are 0; 5th tick spawns with gap_top=2, column 0 rows 2..4 = 0 and others 1; first pipe now at column 4.
REQ-036 The bench SHALL check: 7 ticks after first spawn -> first pipe in column 6; after 9 ticks it has left and column 7 = 0 or a later pipe.
REQ-037 The bench SHALL check: halt and enable asserted in the same cycle -> no shift, state FROZEN; 10 further enables -> green_array unchanged.
REQ-038 The bench SHALL check: clear and halt in the same cycle, then enable -> field cleared; first enable spawns with gap_top=5 again.
REQ-039 The bench SHALL check: reset pulsed low between clock edges during RUN -> green_array=0 immediately, state IDLE; with GAP_H=4 and lfsr[2:0]=7 forced by seed 8'h07, first spawn gives gap_top=2.

Source files
------------

// File: rtl/pipe_gen.sv
// Scrolling pipe-field generator: shifts an 8x8 field one column per tick, spawning LFSR-placed pipes.
// Latency: one cycle from an enable tick to the updated green_array/spawned/gap_top.
// Backpressure: none; halt freezes the field until clear; enable held high gives one tick per clock.
//
// Ports:
//   clk, reset (async, active-low)   - clock and reset
//   enable                           - scroll tick
//   halt                             - game over, freezes the field
//   clear                            - synchronous restart back to IDLE
//   green_array[row][col]            - pipe field; column 6 feeds the score stage
//   spawned                          - pulse the cycle after a pipe enters column 0
//   gap_top                          - lowest gap row of the most recent pipe
module pipe_gen #(
  parameter int         GAP_H     = 3,
  parameter int         SPACING   = 4,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            halt,
  input  logic            clear,
  output logic [7:0][7:0] green_array,
  output logic            spawned,
  output logic [2:0]      gap_top
);

  typedef enum logic [1:0] {IDLE, RUN, FROZEN} state_t;

  // Highest legal gap_top, and the fold-back amount for raw values above it.
  localparam logic [2:0] GAP_MAX  = 3'(8 - GAP_H);
  localparam logic [2:0] GAP_WRAP = 3'(9 - GAP_H);
  localparam logic [3:0] SP_LAST  = 4'(SPACING - 1);

  state_t      state, state_nxt;
  logic        tick;
  logic [3:0]  sp;
  logic [7:0]  lfsr;
  logic [7:0]  lfsr_nxt;
  logic [2:0]  raw;
  logic [2:0]  gap_new;
  logic [7:0]  pipe_col;
  logic [7:0]  new_col;
  logic        spawn_now;

  // Control: clear beats halt beats enable. The IDLE->RUN enable is itself a tick.
  always_comb begin
    state_nxt = state;
    tick      = 1'b0;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (enable && !halt) begin
            state_nxt = RUN;
            tick      = 1'b1;
          end
        end
        RUN: begin
          if (halt) begin
            state_nxt = FROZEN;
          end else if (enable) begin
            tick = 1'b1;
          end
        end
        FROZEN: begin
          state_nxt = FROZEN;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Gap placement from the low LFSR bits, folded so the gap stays inside rows 0..7.
  always_comb begin
    raw      = lfsr[2:0];
    gap_new  = (raw <= GAP_MAX) ? raw : (raw - GAP_WRAP);
    lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    pipe_col = 8'hFF;
    for (int r = 0; r < 8; r++) begin
      if ((4'(r) >= {1'b0, gap_new}) && (4'(r) < ({1'b0, gap_new} + 4'(GAP_H)))) begin
        pipe_col[r] = 1'b0;
      end
    end
    spawn_now = (sp == 4'd0);
    new_col   = spawn_now ? pipe_col : 8'h00;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      green_array <= '0;
      sp          <= 4'd0;
      lfsr        <= LFSR_SEED;
      spawned     <= 1'b0;
      gap_top     <= 3'd0;
    end else begin
      state <= state_nxt;
      if (clear) begin
        green_array <= '0;
        sp          <= 4'd0;
        lfsr        <= LFSR_SEED;
        spawned     <= 1'b0;
        gap_top     <= 3'd0;
      end else begin
        spawned <= 1'b0;
        if (tick) begin
          // Bit c of each row is column c: shift toward column 7, new content into column 0.
          for (int r = 0; r < 8; r++) begin
            green_array[r] <= {green_array[r][6:0], new_col[r]};
          end
          sp <= (sp == SP_LAST) ? 4'd0 : sp + 4'd1;
          if (spawn_now) begin
            spawned <= 1'b1;
            gap_top <= gap_new;
            // Advanced only after its current value has placed this pipe.
            lfsr    <= lfsr_nxt;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_gen.sv
// Bench for pipe_gen: default instance plus a GAP_H=4 / seed 8'h07 instance driven in lockstep.
// Inputs are driven between edges; outputs are sampled 1 time unit after the rising edge.
// A column-list reference model (tick counting, spec gap formula) predicts every output.
module tb_pipe_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, enable, halt, clear;
  logic [7:0][7:0] ga1, ga2;
  logic            sp1, sp2;
  logic [2:0]      gt1, gt2;

  pipe_gen dut (
    .clk(clk), .reset(reset), .enable(enable), .halt(halt), .clear(clear),
    .green_array(ga1), .spawned(sp1), .gap_top(gt1)
  );

  pipe_gen #(.GAP_H(4), .SPACING(4), .LFSR_SEED(8'h07)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .halt(halt), .clear(clear),
    .green_array(ga2), .spawned(sp2), .gap_top(gt2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one entry per instance.
  localparam int SPC   = 4;
  localparam int IDLE_S = 0, RUN_S = 1, FRZ_S = 2;
  int         gh [2] = '{3, 4};
  logic [7:0] seeds [2] = '{8'hA5, 8'h07};
  logic [7:0] mcol [2][8];
  logic [7:0] mlfsr [2];
  logic       mspw [2];
  logic [2:0] mgap [2];
  int         mstate [2];
  int         mticks [2];

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic int gap_of(input logic [7:0] v, input int h);
    int raw;
    raw = int'(v[2:0]);
    return (raw <= 8 - h) ? raw : raw - (9 - h);
  endfunction

  function automatic logic [7:0] pipe_word(input int g, input int h);
    logic [7:0] w;
    for (int r = 0; r < 8; r++) w[r] = !((r >= g) && (r < g + h));
    return w;
  endfunction

  function automatic logic [7:0] colw(input logic [7:0][7:0] g, input int c);
    logic [7:0] w;
    for (int r = 0; r < 8; r++) w[r] = g[r][c];
    return w;
  endfunction

  function automatic logic [63:0] mgrid(input int m);
    logic [7:0][7:0] g;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) g[r][c] = mcol[m][c][r];
    return g;
  endfunction

  task automatic m_clear(input int m);
    for (int c = 0; c < 8; c++) mcol[m][c] = 8'h00;
    mlfsr[m]  = seeds[m];
    mspw[m]   = 1'b0;
    mgap[m]   = 3'd0;
    mstate[m] = IDLE_S;
    mticks[m] = 0;
  endtask

  task automatic m_reset();
    for (int m = 0; m < 2; m++) m_clear(m);
  endtask

  task automatic m_tick(input int m);
    logic [7:0] nc;
    int g;
    nc = 8'h00;
    if (mticks[m] % SPC == 0) begin
      g        = gap_of(mlfsr[m], gh[m]);
      nc       = pipe_word(g, gh[m]);
      mspw[m]  = 1'b1;
      mgap[m]  = 3'(g);
      mlfsr[m] = lfsr_next(mlfsr[m]);
    end
    for (int c = 7; c > 0; c--) mcol[m][c] = mcol[m][c-1];
    mcol[m][0] = nc;
    mticks[m]++;
  endtask

  task automatic m_step(input logic en, input logic hlt, input logic clr);
    for (int m = 0; m < 2; m++) begin
      mspw[m] = 1'b0;
      if (clr) begin
        m_clear(m);
      end else if (mstate[m] == IDLE_S) begin
        if (en && !hlt) begin
          mstate[m] = RUN_S;
          m_tick(m);
        end
      end else if (mstate[m] == RUN_S) begin
        if (hlt) mstate[m] = FRZ_S;
        else if (en) m_tick(m);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".d1.field"},   ga1, mgrid(0));
    chk({tag, ".d1.spawned"}, 64'(sp1), 64'(mspw[0]));
    chk({tag, ".d1.gap_top"}, 64'(gt1), 64'(mgap[0]));
    chk({tag, ".d2.field"},   ga2, mgrid(1));
    chk({tag, ".d2.spawned"}, 64'(sp2), 64'(mspw[1]));
    chk({tag, ".d2.gap_top"}, 64'(gt2), 64'(mgap[1]));
  endtask

  // One clock with the given inputs; inputs return low afterwards so pulses stay single-cycle.
  task automatic step(input logic en, input logic hlt, input logic clr);
    enable = en; halt = hlt; clear = clr;
    @(posedge clk);
    #1;
    m_step(en, hlt, clr);
    enable = 1'b0; halt = 1'b0; clear = 1'b0;
  endtask

  logic [63:0] snap;

  initial begin
    reset = 1'b0; enable = 1'b0; halt = 1'b0; clear = 1'b0;
    m_reset();
    #12;
    chk_model("reset");
    chk("reset.field", ga1, 64'd0);
    reset = 1'b1;

    // Stays in IDLE without a qualifying enable.
    repeat (3) begin
      step(1'b0, 1'b0, 1'b0);
      chk_model("idle");
    end

    // First tick: pipe with gap rows 5..7.
    step(1'b1, 1'b0, 1'b0);
    chk_model("tick1");
    chk("tick1.col0", 64'(colw(ga1, 0)), 64'h1F);
    chk("tick1.spawned", 64'(sp1), 64'd1);
    chk("tick1.gap_top", 64'(gt1), 64'd5);
    chk("tick1.lfsr", 64'(dut.lfsr), 64'h4A);
    chk("tick1.d2.gap_top", 64'(gt2), 64'd2);
    chk("tick1.d2.col0", 64'(colw(ga2, 0)), 64'hC3);

    step(1'b0, 1'b0, 1'b0);
    chk_model("quiet");
    chk("quiet.spawned", 64'(sp1), 64'd0);
    chk("quiet.gap_hold", 64'(gt1), 64'd5);

    // Ticks 2..5, enable held high back to back.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0);
      chk_model("ticks2to5");
    end
    chk("tick5.col0", 64'(colw(ga1, 0)), 64'hE3);
    for (int c = 1; c < 4; c++) chk($sformatf("tick5.col%0d", c), 64'(colw(ga1, c)), 64'h00);
    chk("tick5.col4", 64'(colw(ga1, 4)), 64'h1F);
    chk("tick5.gap_top", 64'(gt1), 64'd2);

    repeat (2) begin
      step(1'b1, 1'b0, 1'b0);
      chk_model("ticks6to7");
    end
    chk("tick7.col6", 64'(colw(ga1, 6)), 64'h1F);

    repeat (2) begin
      step(1'b1, 1'b0, 1'b0);
      chk_model("ticks8to9");
    end
    chk("tick9.col7", 64'(colw(ga1, 7)), 64'h00);

    // Halt with enable: no shift, then frozen against further enables.
    snap = mgrid(0);
    step(1'b1, 1'b1, 1'b0);
    chk_model("halt");
    chk("halt.noshift", ga1, snap);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0);
      chk_model("frozen");
    end
    chk("frozen.field", ga1, snap);

    // Clear wins over halt; restart reproduces the first pipe.
    step(1'b0, 1'b1, 1'b1);
    chk_model("clear");
    chk("clear.field", ga1, 64'd0);
    chk("clear.gap_top", 64'(gt1), 64'd0);
    step(1'b1, 1'b0, 1'b0);
    chk_model("restart");
    chk("restart.gap_top", 64'(gt1), 64'd5);
    chk("restart.col0", 64'(colw(ga1, 0)), 64'h1F);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic en, hlt, clr;
      en  = 1'($urandom_range(0, 1));
      hlt = ($urandom_range(0, 79) == 0);
      clr = ($urandom_range(0, 59) == 0);
      step(en, hlt, clr);
      chk_model("random");
    end

    // Asynchronous reset between edges while scrolling.
    step(1'b0, 1'b0, 1'b1);
    repeat (6) step(1'b1, 1'b0, 1'b0);
    chk_model("prereset");
    #3;
    reset = 1'b0;
    #1;
    m_reset();
    chk("async.d1.field", ga1, 64'd0);
    chk("async.d2.field", ga2, 64'd0);
    chk_model("async");
    #3;
    reset = 1'b1;
    // A halt here is ignored only if the block really is in IDLE.
    step(1'b0, 1'b1, 1'b0);
    chk_model("post_reset_halt");
    step(1'b1, 1'b0, 1'b0);
    chk_model("post_reset_tick");
    chk("post_reset.d1.gap_top", 64'(gt1), 64'd5);
    chk("post_reset.d2.gap_top", 64'(gt2), 64'd2);
    chk("post_reset.d2.col0", 64'(colw(ga2, 0)), 64'hC3);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
